// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the instruction-fetch front end:
//   - default geometry (address width, queue depth, reset pc, pc step)
//   - FSM state encoding for fetch_queue
//   - NOP encoding for squashed instruction slots
//   - fq_credit_ok(): the issue/credit rule shared by the fetch logic
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int                   FQ_ADDR_W   = 12;
  localparam int                   FQ_DEPTH    = 4;
  localparam logic [FQ_ADDR_W-1:0] FQ_RESET_PC = 12'h000;
  localparam int                   FQ_PC_STEP  = 4;

  // RISC-V style "addi x0, x0, 0" used wherever a slot has to be squashed.
  localparam logic [31:0]          FQ_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FQ_BOOT  = 2'd0,
    FQ_RUN   = 2'd1,
    FQ_FLUSH = 2'd2
  } fq_state_e;

  // A new fetch may be issued when queued entries plus the outstanding
  // response leave a free slot, or when the queue is exactly committed but
  // decode frees a slot in the same cycle.
  function automatic logic fq_credit_ok(input int used, input int depth, input logic pop);
    return (used < depth) || ((used == depth) && pop);
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fq_fifo
// Generic synchronous FIFO used to hold {pc, inst} pairs between the ROM and
// decode. Clear has priority over push and pop. Push into a full FIFO and pop
// from an empty FIFO are ignored.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear        drop all entries at the edge
//   push         write push_data at the tail
//   pop          remove the head entry
//   push_data    WIDTH-bit entry to write
//   head_data    WIDTH-bit head entry (registered storage)
//   count        number of occupied entries
//   empty        count == 0
// -----------------------------------------------------------------------------
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = FQ_ADDR_W + 32,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push_s = push && (count_q != CNT_W'(DEPTH));
    do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
    if (clear) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end between the instruction ROM (1-cycle read
// latency) and decode. Issues sequential fetch addresses, buffers returned
// {pc, inst} pairs in a DEPTH-entry FIFO and hands them to decode with a
// valid/ready handshake. A branch redirect discards everything queued or in
// flight and restarts fetching at branch_pc.
//
// Build option: FETCH_BYPASS_EN
//   defined   - with an empty queue in RUN, a returning ROM word is handed to a
//               ready decode stage combinationally (latency N+1), not queued.
//   undefined - every instruction goes through the FIFO (latency N+2), no
//               combinational ROM-to-decode path.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rom_ce, rom_addr       ROM read request (rom_addr is the fetch pc)
//   rom_inst               ROM data, valid the cycle after rom_ce
//   branch, branch_pc      redirect request and target from EX
//   id_ready               decode accepts the head entry
//   id_valid, id_pc,       head entry presented to decode
//   id_inst                (id_inst is 0 while id_valid is 0)
//   q_count                occupied FIFO entries
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = FQ_ADDR_W,
  parameter int                DEPTH    = FQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC),
  parameter int                PC_STEP  = FQ_PC_STEP
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [31:0]            rom_inst,
  input  logic                   branch,
  input  logic [ADDR_W-1:0]      branch_pc,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [31:0]            id_inst,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + 32;

  fq_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;

  logic [CNT_W-1:0]  fifo_count_s;
  logic [ENT_W-1:0]  fifo_head_s;
  logic              fifo_empty_s;
  logic [CNT_W:0]    used_s;
  logic              running_s;
  logic              pop_s;
  logic              rom_ce_s;
  logic              resp_s;
  logic              bypass_s;
  logic              push_s;
  logic              clear_s;

  fq_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .push      (push_s),
    .pop       (pop_s),
    .push_data ({issued_pc_q, rom_inst}),
    .head_data (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  // Credit check, response routing and optional decode bypass.
  always_comb begin
    used_s    = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_q};
    running_s = (state_q == FQ_RUN) || (state_q == FQ_FLUSH);
    // A pop still counts as accepted when a branch clears the queue in the
    // same cycle; EX squashes that instruction.
    pop_s     = ~fifo_empty_s & id_ready;
    if (running_s) begin
      rom_ce_s = fq_credit_ok(int'(used_s), DEPTH, pop_s);
    end else begin
      rom_ce_s = 1'b0;
    end
    // The word returning during FLUSH belongs to the old stream and is dropped.
    resp_s = inflight_q & (state_q == FQ_RUN);
`ifdef FETCH_BYPASS_EN
    bypass_s = fifo_empty_s & resp_s & id_ready;
`else
    bypass_s = 1'b0;
`endif
    push_s  = resp_s & ~bypass_s & ~branch;
    clear_s = branch & (state_q != FQ_BOOT);
  end

  // Decode-side view of the head entry (or the bypassed ROM word).
  always_comb begin
`ifdef FETCH_BYPASS_EN
    if (bypass_s) begin
      id_valid = 1'b1;
      id_pc    = issued_pc_q;
      id_inst  = rom_inst;
    end else if (!fifo_empty_s) begin
      id_valid = 1'b1;
      id_pc    = fifo_head_s[ENT_W-1 -: ADDR_W];
      id_inst  = fifo_head_s[31:0];
    end else begin
      id_valid = 1'b0;
      id_pc    = {ADDR_W{1'b0}};
      id_inst  = 32'h0000_0000;
    end
`else
    if (!fifo_empty_s) begin
      id_valid = 1'b1;
      id_pc    = fifo_head_s[ENT_W-1 -: ADDR_W];
      id_inst  = fifo_head_s[31:0];
    end else begin
      id_valid = 1'b0;
      id_pc    = {ADDR_W{1'b0}};
      id_inst  = 32'h0000_0000;
    end
`endif
  end

  // FSM next state, fetch pc advance and in-flight tracking.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    inflight_d  = inflight_q;
    issued_pc_d = issued_pc_q;
    case (state_q)
      FQ_BOOT: begin
        // One idle cycle; a redirect here only retargets the first fetch.
        state_d    = FQ_RUN;
        inflight_d = 1'b0;
        if (branch) begin
          fetch_pc_d = branch_pc;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
      end
      FQ_RUN, FQ_FLUSH: begin
        inflight_d = rom_ce_s;
        if (rom_ce_s) begin
          issued_pc_d = fetch_pc_q;
        end else begin
          issued_pc_d = issued_pc_q;
        end
        if (branch) begin
          state_d    = FQ_FLUSH;
          fetch_pc_d = branch_pc;
        end else if (rom_ce_s) begin
          state_d    = FQ_RUN;
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end else begin
          state_d    = FQ_RUN;
          fetch_pc_d = fetch_pc_q;
        end
      end
      default: begin
        state_d     = FQ_BOOT;
        fetch_pc_d  = RESET_PC;
        inflight_d  = 1'b0;
        issued_pc_d = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FQ_BOOT;
      fetch_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      issued_pc_q <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  assign rom_ce   = rom_ce_s;
  assign rom_addr = fetch_pc_q;
  assign q_count  = fifo_count_s;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue. A queue-based behavioural model predicts
// every output each cycle; directed phases pin the model with literal values;
// a second instance with RESET_PC=12'hFF8 checks address wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [11:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch;
  logic [11:0] branch_pc;
  logic        id_ready;
  logic        id_valid;
  logic [11:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  q_count;

  logic        rom_ce2;
  logic [11:0] rom_addr2;
  logic [31:0] rom_inst2;
  logic        branch2;
  logic [11:0] branch_pc2;
  logic        id_ready2;
  logic        id_valid2;
  logic [11:0] id_pc2;
  logic [31:0] id_inst2;
  logic [2:0]  q_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(12), .DEPTH(4), .RESET_PC(12'h000), .PC_STEP(4)) u_dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .branch(branch), .branch_pc(branch_pc), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .q_count(q_count)
  );

  fetch_queue #(.ADDR_W(12), .DEPTH(4), .RESET_PC(12'hFF8), .PC_STEP(4)) u_wrap (
    .clk(clk), .rst(rst), .rom_ce(rom_ce2), .rom_addr(rom_addr2), .rom_inst(rom_inst2),
    .branch(branch2), .branch_pc(branch_pc2), .id_ready(id_ready2), .id_valid(id_valid2),
    .id_pc(id_pc2), .id_inst(id_inst2), .q_count(q_count2)
  );

  // ROM contents: every word encodes its own address.
  function automatic logic [31:0] romf(input logic [11:0] a);
    return {8'hC3, 4'h5, a, ~a[7:0]};
  endfunction

  // ---------------- behavioural model (main instance) ----------------
  logic [11:0] pcq[$];
  bit          m_known = 1'b0;
  bit          m_boot, m_flush, m_pend;
  logic [11:0] m_pend_addr, m_nxt;
  bit          e_valid, e_pop, e_ce, e_byp;
  logic [11:0] e_pc, e_addr;
  logic [31:0] e_inst;
  int          e_cnt;

  // ---------------- wrap instance tracking ----------------
  bit          w_known = 1'b0;
  logic [11:0] w_nxt_iss, w_nxt_dec;
  logic [11:0] w_iss[4];
  logic [11:0] w_dec[4];
  int          wi = 0;
  int          wd = 0;

  // ---------------- samples of the last checked cycle ----------------
  logic        s_ce, s_valid;
  logic [11:0] s_addr, s_pc;
  logic [2:0]  s_cnt;
  logic        rd_ce, rd_ce2;
  logic [11:0] rd_addr, rd_addr2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_outputs();
    bit head;
    int used;
    head    = (pcq.size() != 0);
    e_byp   = BYP && !head && !m_boot && !m_flush && m_pend && id_ready;
    e_valid = head || e_byp;
    e_pc    = head ? pcq[0] : (e_byp ? m_pend_addr : 12'h000);
    e_inst  = e_valid ? romf(e_pc) : 32'h0;
    e_pop   = head && id_ready;
    used    = pcq.size() + (m_pend ? 1 : 0);
    e_ce    = !m_boot && ((used < 4) || (used == 4 && e_pop));
    e_addr  = m_nxt;
    e_cnt   = pcq.size();
  endtask

  task automatic model_advance();
    if (rst) begin
      pcq.delete();
      m_boot = 1'b1; m_flush = 1'b0; m_pend = 1'b0; m_nxt = 12'h000; m_pend_addr = 12'h000;
      m_known = 1'b1;
    end else if (m_boot) begin
      if (branch) m_nxt = branch_pc;
      m_boot = 1'b0;
      m_pend = 1'b0;
    end else if (branch) begin
      pcq.delete();
      m_flush     = 1'b1;
      m_pend      = e_ce;
      m_pend_addr = m_nxt;
      m_nxt       = branch_pc;
    end else begin
      if (e_pop) void'(pcq.pop_front());
      if (m_pend && !m_flush && !e_byp) pcq.push_back(m_pend_addr);
      m_pend      = e_ce;
      m_pend_addr = m_nxt;
      if (e_ce) m_nxt = m_nxt + 12'd4;
      m_flush = 1'b0;
    end
  endtask

  // The single per-cycle compare point for both instances.
  task automatic compare();
    if (m_known) begin
      chk("rom_ce", 32'(rom_ce), 32'(e_ce));
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("id_valid", 32'(id_valid), 32'(e_valid));
      if (e_valid) chk("id_pc", 32'(id_pc), 32'(e_pc));
      chk("id_inst", id_inst, e_inst);
      chk("q_count", 32'(q_count), 32'(e_cnt));
    end
    if (w_known) begin
      if (rom_ce2) chk("wrap_rom_addr", 32'(rom_addr2), 32'(w_nxt_iss));
      if (id_valid2) begin
        chk("wrap_id_pc", 32'(id_pc2), 32'(w_nxt_dec));
        chk("wrap_id_inst", id_inst2, romf(w_nxt_dec));
      end
    end
  endtask

  task automatic step(input int br, input int bpc, input int rdy, input int r);
    rst       = (r != 0);
    branch    = (br != 0);
    branch_pc = 12'(bpc);
    id_ready  = (rdy != 0);
    #1;
    model_outputs();
    compare();
    s_ce = rom_ce; s_addr = rom_addr; s_valid = id_valid; s_pc = id_pc; s_cnt = q_count;
    rd_ce = rom_ce; rd_addr = rom_addr; rd_ce2 = rom_ce2; rd_addr2 = rom_addr2;
    model_advance();
    if (rst) begin
      w_nxt_iss = 12'hFF8; w_nxt_dec = 12'hFF8; w_known = 1'b1;
    end else if (w_known) begin
      if (rom_ce2) begin
        if (wi < 4) begin w_iss[wi] = rom_addr2; wi++; end
        w_nxt_iss = w_nxt_iss + 12'd4;
      end
      if (id_valid2) begin
        if (wd < 4) begin w_dec[wd] = id_pc2; wd++; end
        w_nxt_dec = w_nxt_dec + 12'd4;
      end
    end
    @(posedge clk);
    #1;
    rom_inst  = rd_ce  ? romf(rd_addr)  : 32'hDEAD_BEEF;
    rom_inst2 = rd_ce2 ? romf(rd_addr2) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  initial begin
    bit          seen;
    logic [11:0] expd;
    logic [11:0] expw;
    int          n;
    int          lvl;

    rst = 1'b1; branch = 1'b0; branch_pc = 12'h000; id_ready = 1'b0;
    rom_inst = 32'h0; rom_inst2 = 32'h0;
    branch2 = 1'b0; branch_pc2 = 12'h000; id_ready2 = 1'b1;

    // Reset state and start-up sequence.
    do_reset();
    chk("rst_rom_ce", 32'(s_ce), 32'd0);
    chk("rst_rom_addr", 32'(s_addr), 32'd0);
    chk("rst_id_valid", 32'(s_valid), 32'd0);
    chk("rst_q_count", 32'(s_cnt), 32'd0);
    step(0, 0, 1, 0);
    chk("boot_rom_ce", 32'(s_ce), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 1, 0);
      chk("start_rom_ce", 32'(s_ce), 32'd1);
      chk("start_rom_addr", 32'(s_addr), 32'(4 * (k - 1)));
      if ((k - 1 - LAT) >= 0 && (k - 1 - LAT) < 3) begin
        chk("start_id_valid", 32'(s_valid), 32'd1);
        chk("start_id_pc", 32'(s_pc), 32'(4 * (k - 1 - LAT)));
      end
    end

    // Branch with three entries queued and one response in flight.
    do_reset();
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    step(1, 12'h100, 0, 0);
    chk("br_q_count", 32'(s_cnt), 32'd3);
    chk("br_rom_ce", 32'(s_ce), 32'd0);
    step(0, 0, 1, 0);
    chk("flush_id_valid", 32'(s_valid), 32'd0);
    chk("flush_rom_addr", 32'(s_addr), 32'h100);
    chk("flush_rom_ce", 32'(s_ce), 32'd1);
    seen = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step(0, 0, 1, 0);
      if (s_valid && !seen) begin
        seen = 1'b1;
        chk("br_first_pc", 32'(s_pc), 32'h100);
        chk("br_latency", 32'(j), 32'(LAT));
      end
    end
    chk("br_seen", 32'(seen), 32'd1);

    // Decode stalled for ten cycles: queue fills, fetching stops.
    do_reset();
    step(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    chk("stall_q_count", 32'(s_cnt), 32'd4);
    chk("stall_rom_ce", 32'(s_ce), 32'd0);
    chk("stall_rom_addr", 32'(s_addr), 32'd16);
    expd = 12'h000;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 0);
      if (s_valid) begin
        chk("release_order", 32'(s_pc), 32'(expd));
        expd = expd + 12'd4;
        n++;
      end
    end
    chk("release_n_ge5", 32'(n >= 5), 32'd1);

    // Back-to-back branches: only the second target reaches decode.
    step(1, 12'h040, 1, 0);
    step(1, 12'h080, 1, 0);
    expd = 12'h080;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0);
      if (s_valid) begin
        chk("dbl_branch_pc", 32'(s_pc), 32'(expd));
        expd = expd + 12'd4;
        n++;
      end
    end
    chk("dbl_branch_n_ge3", 32'(n >= 3), 32'd1);

    // Wrap-around instance: first issues and first decodes.
    chk("wrap_n_iss", 32'(wi), 32'd4);
    chk("wrap_n_dec", 32'(wd), 32'd4);
    expw = 12'hFF8;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_iss_lit", 32'(w_iss[i]), 32'(expw));
      chk("wrap_dec_lit", 32'(w_dec[i]), 32'(expw));
      expw = expw + 12'd4;
    end

    // Randomised traffic with alternating heavy/light decode back-pressure.
    for (int i = 0; i < 3000; i++) begin
      int b, bpc, rd, r;
      lvl = ((i % 400) < 200) ? 8 : 3;
      r   = ($urandom_range(0, 199) == 0) ? 1 : 0;
      b   = ($urandom_range(0, 19) == 0) ? 1 : 0;
      bpc = ($urandom_range(0, 3) == 0) ? (32'hFF0 | (4 * $urandom_range(0, 3)))
                                        : int'($urandom & 32'hFFC);
      rd  = ($urandom_range(0, 9) < lvl) ? 1 : 0;
      step(b, bpc, rd, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
